if_buffer: RTL and testbench

IF_BUFFER -- requirements
Module: if_buffer

---
 rtl/if_buffer.sv | 152 +++++++++++++++
 tb/tb_if_buffer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/if_buffer.sv
// if_buffer: circular instruction-fetch buffer between fetch and decode.
// Fetch presents up to four consecutive words per cycle; the buffer accepts
// the contiguous valid prefix that fits, and exposes its four oldest entries
// to decode, which reports how many it consumed.
module if_buffer #(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic [31:0] Iin1,
    input  logic [31:0] Iin2,
    input  logic [31:0] Iin3,
    input  logic [31:0] Iin4,
    input  logic        Iin1Valid,
    input  logic        Iin2Valid,
    input  logic        Iin3Valid,
    input  logic        Iin4Valid,
    input  logic [2:0]  out_read_count,
    output logic [31:0] Iout1,
    output logic [31:0] Iout2,
    output logic [31:0] Iout3,
    output logic [31:0] Iout4,
    output logic        Iout1Valid,
    output logic        Iout2Valid,
    output logic        Iout3Valid,
    output logic        Iout4Valid,
    output logic [2:0]  in_count,
    output logic [2:0]  empty_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] FOUR_C  = CW'(4);

    logic [31:0]   mem_r [DEPTH];
    logic [AW-1:0] head_r;
    logic [AW-1:0] tail_r;
    logic [CW-1:0] occ_r;

    logic [31:0]   in_word_s [4];
    logic [2:0]    cand_s;
    logic [2:0]    in_count_s;
    logic [2:0]    empty_s;
    logic [CW-1:0] free_s;
    logic [CW-1:0] orc_ext_s;
    logic [CW-1:0] eff_read_s;
    logic [31:0]   out_word_s [4];
    logic [3:0]    out_valid_s;

    // Gather the fetch words into an array so writes can be indexed.
    always_comb begin
        in_word_s[0] = Iin1;
        in_word_s[1] = Iin2;
        in_word_s[2] = Iin3;
        in_word_s[3] = Iin4;
    end

    // Accept candidates: length of the contiguous valid prefix of the fetch group.
    always_comb begin
        cand_s = 3'd0;
        if (!Iin1Valid) begin
            cand_s = 3'd0;
        end else if (!Iin2Valid) begin
            cand_s = 3'd1;
        end else if (!Iin3Valid) begin
            cand_s = 3'd2;
        end else if (!Iin4Valid) begin
            cand_s = 3'd3;
        end else begin
            cand_s = 3'd4;
        end
    end

    // Acceptance, free-space report and clamped decode consumption; space
    // freed by this cycle's dequeue is deliberately not offered to fetch.
    always_comb begin
        free_s     = DEPTH_C - occ_r;
        in_count_s = 3'd0;
        empty_s    = 3'd0;
        orc_ext_s  = CW'(out_read_count);
        eff_read_s = {CW{1'b0}};
        if (!reset || flush) begin
            in_count_s = 3'd0;
        end else if (CW'(cand_s) <= free_s) begin
            in_count_s = cand_s;
        end else begin
            in_count_s = free_s[2:0];
        end
        if (free_s >= FOUR_C) begin
            empty_s = 3'd4;
        end else begin
            empty_s = free_s[2:0];
        end
        if (orc_ext_s <= occ_r) begin
            eff_read_s = orc_ext_s;
        end else begin
            eff_read_s = occ_r;
        end
    end

    // Read window: the four oldest entries starting at head, masked in reset.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            if (reset) begin
                out_word_s[k]  = mem_r[head_r + AW'(k)];
                out_valid_s[k] = !flush && (occ_r > CW'(k));
            end else begin
                out_word_s[k]  = 32'd0;
                out_valid_s[k] = 1'b0;
            end
        end
    end

    // FIFO state: async clear, flush wins, otherwise enqueue and dequeue together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_r <= {AW{1'b0}};
            tail_r <= {AW{1'b0}};
            occ_r  <= {CW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 32'd0;
            end
        end else if (flush) begin
            head_r <= {AW{1'b0}};
            tail_r <= {AW{1'b0}};
            occ_r  <= {CW{1'b0}};
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (3'(i) < in_count_s) begin
                    mem_r[tail_r + AW'(i)] <= in_word_s[i];
                end
            end
            tail_r <= tail_r + AW'(in_count_s);
            head_r <= head_r + eff_read_s[AW-1:0];
            occ_r  <= occ_r + CW'(in_count_s) - eff_read_s;
        end
    end

    assign Iout1       = out_word_s[0];
    assign Iout2       = out_word_s[1];
    assign Iout3       = out_word_s[2];
    assign Iout4       = out_word_s[3];
    assign Iout1Valid  = out_valid_s[0];
    assign Iout2Valid  = out_valid_s[1];
    assign Iout3Valid  = out_valid_s[2];
    assign Iout4Valid  = out_valid_s[3];
    assign in_count    = in_count_s;
    assign empty_count = empty_s;

endmodule

// File: tb/tb_if_buffer.sv
// tb_if_buffer: directed scenarios plus randomized traffic checked against a
// queue-based model of the instruction buffer.
module tb_if_buffer;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic [31:0] Iin1, Iin2, Iin3, Iin4;
    logic        Iin1Valid, Iin2Valid, Iin3Valid, Iin4Valid;
    logic [2:0]  out_read_count;
    logic [31:0] Iout1, Iout2, Iout3, Iout4;
    logic        Iout1Valid, Iout2Valid, Iout3Valid, Iout4Valid;
    logic [2:0]  in_count;
    logic [2:0]  empty_count;

    logic [31:0] iout_w [4];
    logic [3:0]  vout;

    int checks = 0;
    int errors = 0;

    logic [31:0] words [8];
    logic [31:0] neww  [4];

    if_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .Iin1(Iin1), .Iin2(Iin2), .Iin3(Iin3), .Iin4(Iin4),
        .Iin1Valid(Iin1Valid), .Iin2Valid(Iin2Valid),
        .Iin3Valid(Iin3Valid), .Iin4Valid(Iin4Valid),
        .out_read_count(out_read_count),
        .Iout1(Iout1), .Iout2(Iout2), .Iout3(Iout3), .Iout4(Iout4),
        .Iout1Valid(Iout1Valid), .Iout2Valid(Iout2Valid),
        .Iout3Valid(Iout3Valid), .Iout4Valid(Iout4Valid),
        .in_count(in_count), .empty_count(empty_count)
    );

    always #5 clk = ~clk;

    assign iout_w[0] = Iout1;
    assign iout_w[1] = Iout2;
    assign iout_w[2] = Iout3;
    assign iout_w[3] = Iout4;
    assign vout = {Iout4Valid, Iout3Valid, Iout2Valid, Iout1Valid};

    // Drive one cycle's inputs; v[0] is Iin1Valid.
    task automatic set_inputs(input logic fl, input logic [3:0] v,
                              input logic [31:0] w1, input logic [31:0] w2,
                              input logic [31:0] w3, input logic [31:0] w4,
                              input logic [2:0] orc);
        flush = fl;
        Iin1Valid = v[0]; Iin2Valid = v[1]; Iin3Valid = v[2]; Iin4Valid = v[3];
        Iin1 = w1; Iin2 = w2; Iin3 = w3; Iin4 = w4;
        out_read_count = orc;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        set_inputs(1'b0, 4'b1111, 32'h1, 32'h2, 32'h3, 32'h4, 3'd2);
        #2;
        checks++; if (in_count !== 3'd0) begin errors++; $display("FAIL reset_in_count got %0d exp 0", in_count); end
        checks++; if (empty_count !== 3'd4) begin errors++; $display("FAIL reset_empty got %0d exp 4", empty_count); end
        checks++; if (vout !== 4'b0000) begin errors++; $display("FAIL reset_valid got %b exp 0000", vout); end
        for (int k = 0; k < 4; k++) begin
            checks++; if (iout_w[k] !== 32'd0) begin errors++; $display("FAIL reset_iout%0d got %h exp 0", k + 1, iout_w[k]); end
        end
        set_inputs(1'b0, 4'b0000, 32'h0, 32'h0, 32'h0, 32'h0, 3'd0);
        @(negedge clk);
        reset = 1'b1;
        step();
    endtask

    task automatic test_fill();
        set_inputs(1'b0, 4'b1111, words[0], words[1], words[2], words[3], 3'd0);
        #1;
        checks++; if (in_count !== 3'd4) begin errors++; $display("FAIL fill1_in_count got %0d exp 4", in_count); end
        step();
        for (int k = 0; k < 4; k++) begin
            checks++; if (iout_w[k] !== words[k] || vout[k] !== 1'b1) begin errors++; $display("FAIL fill1_iout%0d got %h/%b exp %h/1", k + 1, iout_w[k], vout[k], words[k]); end
        end
        checks++; if (empty_count !== 3'd4) begin errors++; $display("FAIL fill1_empty got %0d exp 4", empty_count); end
        set_inputs(1'b0, 4'b1111, words[4], words[5], words[6], words[7], 3'd0);
        #1;
        checks++; if (in_count !== 3'd4) begin errors++; $display("FAIL fill2_in_count got %0d exp 4", in_count); end
        step();
        checks++; if (empty_count !== 3'd0) begin errors++; $display("FAIL fill2_empty got %0d exp 0", empty_count); end
        set_inputs(1'b0, 4'b1111, neww[0], neww[1], neww[2], neww[3], 3'd0);
        #1;
        checks++; if (in_count !== 3'd0) begin errors++; $display("FAIL full_in_count got %0d exp 0", in_count); end
        step();
    endtask

    task automatic test_wrap();
        set_inputs(1'b0, 4'b1111, neww[0], neww[1], neww[2], neww[3], 3'd3);
        #1;
        checks++; if (in_count !== 3'd0) begin errors++; $display("FAIL wrap_in_count0 got %0d exp 0", in_count); end
        step();
        checks++; if (Iout1 !== words[3]) begin errors++; $display("FAIL wrap_iout1 got %h exp %h", Iout1, words[3]); end
        checks++; if (empty_count !== 3'd3) begin errors++; $display("FAIL wrap_empty got %0d exp 3", empty_count); end
        set_inputs(1'b0, 4'b1111, neww[0], neww[1], neww[2], neww[3], 3'd0);
        #1;
        checks++; if (in_count !== 3'd3) begin errors++; $display("FAIL wrap_in_count3 got %0d exp 3", in_count); end
        step();
        checks++; if (empty_count !== 3'd0) begin errors++; $display("FAIL wrap_full got %0d exp 0", empty_count); end
        for (int k = 0; k < 4; k++) begin
            checks++; if (iout_w[k] !== words[3 + k]) begin errors++; $display("FAIL wrap_a_iout%0d got %h exp %h", k + 1, iout_w[k], words[3 + k]); end
        end
        set_inputs(1'b0, 4'b0000, 32'h0, 32'h0, 32'h0, 32'h0, 3'd4);
        step();
        checks++; if (Iout1 !== words[7]) begin errors++; $display("FAIL wrap_b_iout1 got %h exp %h", Iout1, words[7]); end
        for (int k = 1; k < 4; k++) begin
            checks++; if (iout_w[k] !== neww[k - 1] || vout[k] !== 1'b1) begin errors++; $display("FAIL wrap_b_iout%0d got %h exp %h", k + 1, iout_w[k], neww[k - 1]); end
        end
    endtask

    task automatic test_flush();
        // occupancy 4 -> 6 with a two-word valid prefix
        set_inputs(1'b0, 4'b1011, 32'hF1, 32'hF2, 32'hF3, 32'hF4, 3'd0);
        #1;
        checks++; if (in_count !== 3'd2) begin errors++; $display("FAIL flush_pre_in_count got %0d exp 2", in_count); end
        step();
        checks++; if (empty_count !== 3'd2) begin errors++; $display("FAIL flush_pre_empty got %0d exp 2", empty_count); end
        set_inputs(1'b1, 4'b1111, 32'hF5, 32'hF6, 32'hF7, 32'hF8, 3'd2);
        #1;
        checks++; if (in_count !== 3'd0) begin errors++; $display("FAIL flush_in_count got %0d exp 0", in_count); end
        checks++; if (vout !== 4'b0000) begin errors++; $display("FAIL flush_valid got %b exp 0000", vout); end
        step();
        set_inputs(1'b0, 4'b0000, 32'h0, 32'h0, 32'h0, 32'h0, 3'd0);
        #1;
        checks++; if (empty_count !== 3'd4) begin errors++; $display("FAIL flush_empty got %0d exp 4", empty_count); end
        checks++; if (vout !== 4'b0000) begin errors++; $display("FAIL flush_after_valid got %b exp 0000", vout); end
        step();
    endtask

    task automatic test_prefix();
        set_inputs(1'b0, 4'b0101, 32'hC1, 32'hC2, 32'hC3, 32'hC4, 3'd0);
        #1;
        checks++; if (in_count !== 3'd1) begin errors++; $display("FAIL prefix_in_count got %0d exp 1", in_count); end
        step();
        checks++; if (vout !== 4'b0001) begin errors++; $display("FAIL prefix_valid got %b exp 0001", vout); end
        checks++; if (Iout1 !== 32'hC1) begin errors++; $display("FAIL prefix_iout1 got %h exp c1", Iout1); end
    endtask

    task automatic test_underflow_and_async_reset();
        set_inputs(1'b0, 4'b0001, 32'hD1, 32'h0, 32'h0, 32'h0, 3'd0);
        step();
        checks++; if (vout !== 4'b0011) begin errors++; $display("FAIL uf_pre_valid got %b exp 0011", vout); end
        set_inputs(1'b0, 4'b0000, 32'h0, 32'h0, 32'h0, 32'h0, 3'd4);
        step();
        set_inputs(1'b0, 4'b0000, 32'h0, 32'h0, 32'h0, 32'h0, 3'd0);
        #1;
        checks++; if (vout !== 4'b0000) begin errors++; $display("FAIL uf_valid got %b exp 0000", vout); end
        checks++; if (empty_count !== 3'd4) begin errors++; $display("FAIL uf_empty got %0d exp 4", empty_count); end
        // refill to two entries, then pulse reset between edges
        set_inputs(1'b0, 4'b0011, 32'hE1, 32'hE2, 32'h0, 32'h0, 3'd0);
        step();
        checks++; if (vout !== 4'b0011) begin errors++; $display("FAIL ar_pre_valid got %b exp 0011", vout); end
        set_inputs(1'b0, 4'b0000, 32'h0, 32'h0, 32'h0, 32'h0, 3'd0);
        @(negedge clk);
        reset = 1'b0;
        set_inputs(1'b0, 4'b1111, 32'h1, 32'h2, 32'h3, 32'h4, 3'd0);
        #1;
        checks++; if (vout !== 4'b0000) begin errors++; $display("FAIL ar_valid got %b exp 0000", vout); end
        checks++; if (Iout1 !== 32'd0) begin errors++; $display("FAIL ar_iout1 got %h exp 0", Iout1); end
        checks++; if (in_count !== 3'd0) begin errors++; $display("FAIL ar_in_count got %0d exp 0", in_count); end
        checks++; if (empty_count !== 3'd4) begin errors++; $display("FAIL ar_empty got %0d exp 4", empty_count); end
        set_inputs(1'b0, 4'b0000, 32'h0, 32'h0, 32'h0, 32'h0, 3'd0);
        #1;
        reset = 1'b1;
        step();
        set_inputs(1'b0, 4'b1111, 32'hB1, 32'hB2, 32'hB3, 32'hB4, 3'd0);
        #1;
        checks++; if (in_count !== 3'd4) begin errors++; $display("FAIL ar_after_in_count got %0d exp 4", in_count); end
        step();
        checks++; if (Iout1 !== 32'hB1 || vout !== 4'b1111) begin errors++; $display("FAIL ar_after_iout1 got %h/%b exp b1/1111", Iout1, vout); end
    endtask

    task automatic test_random();
        logic [31:0] q[$];
        logic [31:0] w [4];
        logic [3:0]  v;
        logic [2:0]  orc;
        logic        fl;
        int          cand;
        int          exp_in;
        int          exp_empty;
        int          n;
        bit          stop;
        // start from an empty buffer
        set_inputs(1'b1, 4'b0000, 32'h0, 32'h0, 32'h0, 32'h0, 3'd0);
        step();
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int i = 0; i < 4; i++) w[i] = $urandom;
            v   = ($urandom_range(0, 9) < 6) ? 4'b1111 : 4'($urandom_range(0, 15));
            orc = 3'($urandom_range(0, 4));
            fl  = ($urandom_range(0, 29) == 0);
            set_inputs(fl, v, w[0], w[1], w[2], w[3], orc);
            cand = 0; stop = 1'b0;
            for (int i = 0; i < 4; i++) begin
                if (!stop && v[i]) cand++; else stop = 1'b1;
            end
            exp_in = fl ? 0 : ((cand < DEPTH - q.size()) ? cand : DEPTH - q.size());
            exp_empty = (DEPTH - q.size() > 4) ? 4 : DEPTH - q.size();
            #1;
            checks++; if (in_count !== 3'(exp_in)) begin errors++; $display("FAIL rnd_in_count cyc %0d got %0d exp %0d", cyc, in_count, exp_in); end
            checks++; if (empty_count !== 3'(exp_empty)) begin errors++; $display("FAIL rnd_empty cyc %0d got %0d exp %0d", cyc, empty_count, exp_empty); end
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (vout[k] !== (!fl && q.size() > k)) begin
                    errors++; $display("FAIL rnd_valid%0d cyc %0d got %b exp %b", k + 1, cyc, vout[k], (!fl && q.size() > k));
                end else if (vout[k] && iout_w[k] !== q[k]) begin
                    errors++; $display("FAIL rnd_iout%0d cyc %0d got %h exp %h", k + 1, cyc, iout_w[k], q[k]);
                end
            end
            step();
            if (fl) begin
                q.delete();
            end else begin
                n = (int'(orc) < q.size()) ? int'(orc) : q.size();
                for (int i = 0; i < n; i++) void'(q.pop_front());
                for (int i = 0; i < exp_in; i++) q.push_back(w[i]);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) words[i] = 32'hA000_0000 + 32'(i);
        for (int i = 0; i < 4; i++) neww[i]  = 32'h5000_0000 + 32'(i);
        reset = 1'b0;
        set_inputs(1'b0, 4'b0000, 32'h0, 32'h0, 32'h0, 32'h0, 3'd0);
        #7;
        test_reset();
        test_fill();
        test_wrap();
        test_flush();
        test_prefix();
        test_underflow_and_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
